mips_fetch_exec_mem: RTL and testbench
======================================

// Module: mips_fetch_exec_mem
// PURPOSE
// - Fetch/execute/memory slice of the single-cycle MIPS core: instruction ROM, 32-bit ALU and word data RAM.
// - Sits between the pc register and the register file.
// - Caller supplies the PC, the register operands and the store data.
// - Caller already applies the sign-extended-immediate mux to ALU operand B.
// PARAMETERS
// IMEM_DEPTH  256  instruction words in ROM (power of 2)
// DMEM_DEPTH  256  data words in RAM (power of 2)
// PORTS
// clk           in   1   single clock, rising edge
// rst           in   1   asynchronous reset, active-high
// read_address  in   32  byte address of instruction (pc)
// instruction   out  32  fetched instruction word
// busA          in   32  ALU operand A (register RS)
// busB          in   32  ALU operand B (RT value or sign-extended imm16, muxed by caller)
// store_data    in   32  data memory write data (RT value)
// dmem_write    in   1   data memory write enable
// alu_result    out  32  ALU result; also the data memory byte address
// zero          out  1   1 when alu_result == 0
// dmem_out      out  32  data memory read word at alu_result
// BEHAVIOUR
// - One clock; reset is asynchronous and active-high.
// - Instruction ROM:
//   - combinational read, instruction = rom[read_address[log2(IMEM_DEPTH)+1:2]]; bits [1:0] ignored.
//   - Addresses above the depth wrap modulo IMEM_DEPTH.
//   - Contents are constant and unaffected by rst.
//   - word0 = 0x3C010007 (lui $1,7); word1 = 0x20220005 (addi $2,$1,5); all other words 0x00000000 (nop).
// - ALU: purely combinational, zero latency; decode uses instruction[31:26] (opcode) and [5:0] (funct).
//   - R-type (op 0x00), by funct:
//     - 0x20/0x21 A+B; 0x22/0x23 A-B.
//     - 0x24 AND; 0x25 OR; 0x26 XOR; 0x27 NOR.
//     - 0x2A signed A<B ? 1:0; 0x2B unsigned A<B ? 1:0.
//     - any other funct -> 0.
//   - I-type, by opcode:
//     - 0x08/0x09 A+B; 0x23 LW and 0x2B SW A+B (address).
//     - 0x04/0x05 BEQ/BNE A-B; zero drives the branch decision.
//     - 0x0A signed SLT; 0x0B unsigned SLT.
//     - 0x0C/0x0D/0x0E AND/OR/XOR of A with {16'h0,B[15:0]} (zero-extended).
//     - 0x0F LUI: result = B unchanged. Deliberate core simplification: lui $1,7 yields 7.
//   - Unknown opcode -> result 0.
//   - All adds/subtracts wrap mod 2^32; no overflow trap or flag.
// - Data RAM:
//   - word-addressed by alu_result[log2(DMEM_DEPTH)+1:2]; bits [1:0] ignored; wraps modulo depth.
//   - Read is combinational: dmem_out = mem[idx].
//   - Write on rising clk when dmem_write=1 and rst=0: mem[idx] <= store_data.
//   - Read of the word being written shows old data until the edge, new data after it.
//   - rst asserted (any time, async): every word clears to 0 immediately; writes are blocked while rst=1.
// - Reset values:
//   - dmem_out = 0.
//   - instruction and alu_result/zero are combinational functions of the inputs; rst does not force them.
// STRUCTURE
// - Shared header opcodes.v holds:
//   - OP_* opcode and FUNCT_* constants.
//   - I_TYPE_INSTRUCTION(op) macro (op != 0).
//   - IS_MEMORY_ACCESS(op) macro (LW or SW).
// - Three leaf sub-modules instantiated by this wrapper:
//   - instruction_memory (read_address, instruction, clk, rst)
//   - alu (opcode, funct, busA, busB, result, zero, clk, rst)
//   - data_memory (address, write_enable, data_in, data_out, rst, clk)
// - clk and rst are unused inside alu and instruction_memory; they are kept for uniform hookup.
// TESTING
// - Fetch: read_address 0 -> instruction 0x3C010007; address 4 -> 0x20220005; address 8 -> 0.
// - LUI/ADDI chain:
//   - word0 with busB=7 -> alu_result 7, zero 0.
//   - word1 with busA=7, busB=5 -> alu_result 12.
// - R-type SUB (funct 0x22): A=5, B=5 -> result 0, zero=1; A=3, B=5 -> 0xFFFFFFFE.
// - SLT vs SLTU with A=0xFFFFFFFF, B=1: SLT -> 1, SLTU -> 0.
// - ORI with B=0xFFFF8000 -> uses 0x00008000 only.
// - SW then LW:
//   - alu_result 0x10, store_data 0xDEADBEEF, dmem_write=1 for one edge.
//   - Then dmem_out at 0x10 = 0xDEADBEEF; address 0x410 (wrap, depth 256) -> same word.
// - Async reset mid-run: pulse rst between clock edges -> dmem_out 0 at every address immediately.
// - Write with dmem_write=1 during rst -> ignored.

Source files
------------

// File: rtl/mips_fetch_exec_mem_pkg.sv
// ----------------------------------------------------------------------------
// mips_fetch_exec_mem_pkg
// Shared definitions for the fetch/execute/memory slice of the single-cycle
// MIPS core:
//   - OP_* opcode and FUNCT_* function-code constants
//   - is_i_type_instruction(op)  : opcode is not the R-type group (op != 0)
//   - is_memory_access(op)       : opcode is LW or SW
//   - alu_op_e / alu_ctrl_t      : internal ALU operation selector
//   - decode_alu(opcode, funct)  : maps instruction fields to an ALU control
//   - Default ROM contents for the first two instruction words
// ----------------------------------------------------------------------------
package mips_fetch_exec_mem_pkg;

    // Opcodes (instruction[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (instruction[5:0])
    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_XOR  = 6'h26;
    localparam logic [5:0] FUNCT_NOR  = 6'h27;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;
    localparam logic [5:0] FUNCT_SLTU = 6'h2B;

    // Fixed boot program held in the instruction ROM
    localparam logic [31:0] ROM_WORD0 = 32'h3C01_0007; // lui  $1,7
    localparam logic [31:0] ROM_WORD1 = 32'h2022_0005; // addi $2,$1,5
    localparam logic [31:0] ROM_NOP   = 32'h0000_0000;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_NOR,
        ALU_SLT,
        ALU_SLTU,
        ALU_PASSB,
        ALU_ZERO
    } alu_op_e;

    typedef struct packed {
        alu_op_e op;
        logic    zext_b;   // use {16'h0, B[15:0]} instead of B
    } alu_ctrl_t;

    function automatic logic is_i_type_instruction(input logic [5:0] op);
        return (op != OP_RTYPE);
    endfunction

    function automatic logic is_memory_access(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic alu_ctrl_t decode_alu(input logic [5:0] opcode,
                                             input logic [5:0] funct);
        alu_ctrl_t c;
        c.op     = ALU_ZERO;
        c.zext_b = 1'b0;
        if (!is_i_type_instruction(opcode)) begin
            case (funct)
                FUNCT_ADD, FUNCT_ADDU: c.op = ALU_ADD;
                FUNCT_SUB, FUNCT_SUBU: c.op = ALU_SUB;
                FUNCT_AND:             c.op = ALU_AND;
                FUNCT_OR:              c.op = ALU_OR;
                FUNCT_XOR:             c.op = ALU_XOR;
                FUNCT_NOR:             c.op = ALU_NOR;
                FUNCT_SLT:             c.op = ALU_SLT;
                FUNCT_SLTU:            c.op = ALU_SLTU;
                default:               c.op = ALU_ZERO;
            endcase
        end else begin
            case (opcode)
                OP_ADDI, OP_ADDIU, OP_LW, OP_SW: c.op = ALU_ADD;
                OP_BEQ, OP_BNE:                  c.op = ALU_SUB;
                OP_SLTI:                         c.op = ALU_SLT;
                OP_SLTIU:                        c.op = ALU_SLTU;
                OP_ANDI: begin c.op = ALU_AND; c.zext_b = 1'b1; end
                OP_ORI:  begin c.op = ALU_OR;  c.zext_b = 1'b1; end
                OP_XORI: begin c.op = ALU_XOR; c.zext_b = 1'b1; end
                // The core treats LUI as "pass the immediate through";
                // the upper-half shift is intentionally not modelled here.
                OP_LUI:                          c.op = ALU_PASSB;
                default:                         c.op = ALU_ZERO;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/mips_fetch_exec_mem_alu.sv
// ----------------------------------------------------------------------------
// alu
// Purely combinational 32-bit ALU decoded from opcode/funct.
// Ports:
//   clk, rst  : unused, kept so every leaf hooks up the same way
//   opcode    : instruction[31:26]
//   funct     : instruction[5:0] (only meaningful for R-type)
//   busA      : operand A (RS)
//   busB      : operand B (RT or sign-extended immediate, muxed upstream)
//   result    : ALU result, arithmetic wraps mod 2^32
//   zero      : result == 0 (drives BEQ/BNE decision)
// ----------------------------------------------------------------------------
module alu
    import mips_fetch_exec_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [31:0] busA,
    input  logic [31:0] busB,
    output logic [31:0] result,
    output logic        zero
);

    alu_ctrl_t   w_ctrl;
    logic [31:0] w_b;
    logic        w_unused;

    assign w_unused = &{1'b0, clk, rst};

    assign w_ctrl = decode_alu(opcode, funct);

    // Logical immediates are zero-extended, so the upstream sign extension
    // is undone here by keeping only the low half.
    assign w_b = w_ctrl.zext_b ? {16'h0000, busB[15:0]} : busB;

    always_comb begin
        result = 32'h0000_0000;
        case (w_ctrl.op)
            ALU_ADD:   result = busA + w_b;
            ALU_SUB:   result = busA - w_b;
            ALU_AND:   result = busA & w_b;
            ALU_OR:    result = busA | w_b;
            ALU_XOR:   result = busA ^ w_b;
            ALU_NOR:   result = ~(busA | w_b);
            ALU_SLT:   result = {31'b0, ($signed(busA) < $signed(w_b))};
            ALU_SLTU:  result = {31'b0, (busA < w_b)};
            ALU_PASSB: result = w_b;
            default:   result = 32'h0000_0000;
        endcase
    end

    assign zero = (result == 32'h0000_0000);

endmodule

// File: rtl/mips_fetch_exec_mem_dmem.sv
// ----------------------------------------------------------------------------
// data_memory
// Word RAM: combinational read, synchronous write, asynchronous clear.
// Ports:
//   clk           : rising-edge write clock
//   rst           : async active-high; clears every word and blocks writes
//   address       : byte address; bits [1:0] ignored, wraps mod depth
//   write_enable  : write data_in at the next rising edge
//   data_in       : store data
//   data_out      : word at address (old value until the write edge)
// ----------------------------------------------------------------------------
module data_memory #(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic        write_enable,
    input  logic [31:0] data_in,
    output logic [31:0] data_out
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] w_idx;
    logic          w_unused;

    assign w_idx    = address[AW+1:2];
    assign w_unused = &{1'b0, address[31:AW+2], address[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'h0000_0000;
            end
        end else if (write_enable) begin
            r_mem[w_idx] <= data_in;
        end
    end

    assign data_out = r_mem[w_idx];

endmodule

// File: rtl/mips_fetch_exec_mem_imem.sv
// ----------------------------------------------------------------------------
// instruction_memory
// Constant instruction ROM with a combinational read.
// Ports:
//   clk, rst      : unused, kept so every leaf hooks up the same way
//   read_address  : byte address (pc); bits [1:0] ignored, wraps mod depth
//   instruction   : fetched 32-bit word
// ----------------------------------------------------------------------------
module instruction_memory
    import mips_fetch_exec_mem_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] read_address,
    output logic [31:0] instruction
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] w_idx;
    logic          w_unused;

    // Dropping the upper address bits gives the modulo-depth wrap.
    assign w_idx    = read_address[AW+1:2];
    assign w_unused = &{1'b0, clk, rst, read_address[31:AW+2], read_address[1:0]};

    always_comb begin
        instruction = ROM_NOP;
        if (w_idx == AW'(0)) begin
            instruction = ROM_WORD0;
        end else if (w_idx == AW'(1)) begin
            instruction = ROM_WORD1;
        end
    end

endmodule

// File: rtl/mips_fetch_exec_mem.sv
// ----------------------------------------------------------------------------
// mips_fetch_exec_mem
// Fetch/execute/memory slice of the single-cycle MIPS core. Sits between the
// pc register and the register file: the caller supplies pc, register
// operands (with the immediate mux already applied to busB) and store data.
// Ports:
//   clk, rst      : clock (rising edge), async active-high reset
//   read_address  : pc byte address        -> instruction : fetched word
//   busA, busB    : ALU operands           -> alu_result, zero
//   store_data    : RAM write data
//   dmem_write    : RAM write enable
//   dmem_out      : RAM word at alu_result (cleared by rst)
// The ALU is decoded from the fetched instruction, and its result is the
// data memory byte address.
// ----------------------------------------------------------------------------
module mips_fetch_exec_mem
    import mips_fetch_exec_mem_pkg::*;
#(
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] read_address,
    output logic [31:0] instruction,
    input  logic [31:0] busA,
    input  logic [31:0] busB,
    input  logic [31:0] store_data,
    input  logic        dmem_write,
    output logic [31:0] alu_result,
    output logic        zero,
    output logic [31:0] dmem_out
);

    logic [31:0] w_instr;
    logic [31:0] w_alu_result;
    logic        w_unused;

    // Only opcode and funct drive this slice; register/immediate fields are
    // consumed by the register file and immediate mux outside.
    assign w_unused = &{1'b0, w_instr[25:6]};

    instruction_memory #(
        .DEPTH (IMEM_DEPTH)
    ) u_imem (
        .clk          (clk),
        .rst          (rst),
        .read_address (read_address),
        .instruction  (w_instr)
    );

    alu u_alu (
        .clk    (clk),
        .rst    (rst),
        .opcode (w_instr[31:26]),
        .funct  (w_instr[5:0]),
        .busA   (busA),
        .busB   (busB),
        .result (w_alu_result),
        .zero   (zero)
    );

    data_memory #(
        .DEPTH (DMEM_DEPTH)
    ) u_dmem (
        .clk          (clk),
        .rst          (rst),
        .address      (w_alu_result),
        .write_enable (dmem_write),
        .data_in      (store_data),
        .data_out     (dmem_out)
    );

    assign instruction = w_instr;
    assign alu_result  = w_alu_result;

endmodule

// File: tb/tb_mips_fetch_exec_mem.sv
module tb_mips_fetch_exec_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] read_address;
    logic [31:0] instruction;
    logic [31:0] busA;
    logic [31:0] busB;
    logic [31:0] store_data;
    logic        dmem_write;
    logic [31:0] alu_result;
    logic        zero;
    logic [31:0] dmem_out;

    // standalone ALU, reachable with any opcode/funct
    logic [5:0]  al_op;
    logic [5:0]  al_fn;
    logic [31:0] al_a;
    logic [31:0] al_b;
    logic [31:0] al_res;
    logic        al_zero;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] ref_mem [256];

    always #5 clk = ~clk;

    mips_fetch_exec_mem dut (
        .clk          (clk),
        .rst          (rst),
        .read_address (read_address),
        .instruction  (instruction),
        .busA         (busA),
        .busB         (busB),
        .store_data   (store_data),
        .dmem_write   (dmem_write),
        .alu_result   (alu_result),
        .zero         (zero),
        .dmem_out     (dmem_out)
    );

    alu u_alu_tb (
        .clk    (clk),
        .rst    (rst),
        .opcode (al_op),
        .funct  (al_fn),
        .busA   (al_a),
        .busB   (al_b),
        .result (al_res),
        .zero   (al_zero)
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] rom_model(input logic [31:0] a);
        logic [31:0] idx;
        idx = (a / 4) % 256;
        if (idx == 0) return 32'h3C010007;
        if (idx == 1) return 32'h20220005;
        return 32'h0;
    endfunction

    function automatic int mem_idx(input logic [31:0] a);
        return int'((a / 4) % 256);
    endfunction

    function automatic logic [31:0] alu_model(input logic [5:0] op, input logic [5:0] fn,
                                              input logic [31:0] a, input logic [31:0] b);
        logic [31:0] imm;
        imm = b % 32'h10000;
        if (op == 0) begin
            case (fn)
                6'h20, 6'h21: return a + b;
                6'h22, 6'h23: return a - b;
                6'h24: return a & b;
                6'h25: return a | b;
                6'h26: return a ^ b;
                6'h27: return ~(a | b);
                6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                6'h2B: return (a < b) ? 32'd1 : 32'd0;
                default: return 32'd0;
            endcase
        end
        case (op)
            6'h08, 6'h09, 6'h23, 6'h2B: return a + b;
            6'h04, 6'h05: return a - b;
            6'h0A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'h0B: return (a < b) ? 32'd1 : 32'd0;
            6'h0C: return a & imm;
            6'h0D: return a | imm;
            6'h0E: return a ^ imm;
            6'h0F: return b;
            default: return 32'd0;
        endcase
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic run_alu(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp;
        al_op = op; al_fn = fn; al_a = a; al_b = b;
        #1;
        exp = alu_model(op, fn, a, b);
        check({tag, "_res"}, al_res, exp);
        check({tag, "_zero"}, {31'b0, al_zero}, {31'b0, (exp == 32'd0)});
    endtask

    task automatic top_step(input string tag, input logic [31:0] pc,
                            input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ins;
        logic [31:0] exp;
        read_address = pc; busA = a; busB = b;
        #1;
        ins = rom_model(pc);
        exp = alu_model(ins[31:26], ins[5:0], a, b);
        check({tag, "_instr"}, instruction, ins);
        check({tag, "_alu"}, alu_result, exp);
        check({tag, "_zero"}, {31'b0, zero}, {31'b0, (exp == 32'd0)});
    endtask

    // word0 is LUI, so alu_result == busB gives direct control of the address
    task automatic mem_read(input string tag, input logic [31:0] addr);
        read_address = 32'h0; busB = addr; busA = $urandom;
        #1;
        check(tag, dmem_out, ref_mem[mem_idx(addr)]);
    endtask

    task automatic mem_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        read_address = 32'h0; busB = addr; busA = $urandom;
        store_data = data; dmem_write = 1'b1;
        #1;
        check("wr_pre_edge_old", dmem_out, ref_mem[mem_idx(addr)]);
        @(posedge clk);
        #1;
        dmem_write = 1'b0;
        if (!rst) ref_mem[mem_idx(addr)] = data;
        check("wr_post_edge_new", dmem_out, ref_mem[mem_idx(addr)]);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [5:0]  op_tab [15];
        logic [5:0]  fn_tab [12];
        logic [31:0] addr;
        op_tab = '{6'h00, 6'h00, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B,
                   6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h3F};
        fn_tab = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                   6'h2A, 6'h2B, 6'h00, 6'h3E};
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;

        // reset state
        rst = 1'b1; dmem_write = 1'b0; store_data = 32'h0;
        read_address = 32'h0; busA = 32'h0; busB = 32'h0;
        al_op = 6'h0; al_fn = 6'h0; al_a = 32'h0; al_b = 32'h0;
        #2;
        check("reset_dmem_out", dmem_out, 32'h0);
        check("reset_instr", instruction, 32'h3C010007);
        @(negedge clk);
        rst = 1'b0;

        // fetch, including ignored low bits and wrap
        top_step("fetch0", 32'h0, 32'h0, 32'h7);
        top_step("fetch4", 32'h4, 32'h7, 32'h5);
        top_step("fetch8", 32'h8, 32'h1234, 32'h5678);
        top_step("fetch3_lowbits", 32'h3, 32'h0, 32'h9);
        top_step("fetch_wrap404", 32'h404, 32'h1, 32'h2);
        top_step("fetch_far", 32'hFFFF_FC00, 32'h0, 32'h0);

        // LUI/ADDI chain with the literal expected values
        read_address = 32'h0; busA = 32'h0; busB = 32'h7; #1;
        check("lui_result", alu_result, 32'h7);
        check("lui_zero", {31'b0, zero}, 32'h0);
        read_address = 32'h4; busA = 32'h7; busB = 32'h5; #1;
        check("addi_result", alu_result, 32'd12);

        // standalone ALU directed points
        run_alu("sub_eq", 6'h00, 6'h22, 32'd5, 32'd5);
        check("sub_eq_lit", al_res, 32'h0);
        run_alu("sub_neg", 6'h00, 6'h22, 32'd3, 32'd5);
        check("sub_neg_lit", al_res, 32'hFFFF_FFFE);
        run_alu("slt", 6'h00, 6'h2A, 32'hFFFF_FFFF, 32'd1);
        check("slt_lit", al_res, 32'd1);
        run_alu("sltu", 6'h00, 6'h2B, 32'hFFFF_FFFF, 32'd1);
        check("sltu_lit", al_res, 32'd0);
        run_alu("ori", 6'h0D, 6'h00, 32'h0, 32'hFFFF_8000);
        check("ori_lit", al_res, 32'h0000_8000);
        run_alu("slti_i", 6'h0A, 6'h00, 32'h8000_0000, 32'h0);
        run_alu("beq", 6'h04, 6'h11, 32'hABCD, 32'hABCD);
        run_alu("bad_op", 6'h3F, 6'h20, 32'h5, 32'h6);
        run_alu("bad_fn", 6'h00, 6'h3E, 32'h5, 32'h6);
        run_alu("add_wrap", 6'h00, 6'h20, 32'hFFFF_FFFF, 32'h2);

        // random ALU operations
        for (int i = 0; i < 80; i++) begin
            logic [5:0] op;
            logic [5:0] fn;
            op = op_tab[$urandom_range(0, 14)];
            fn = (op == 6'h00) ? fn_tab[$urandom_range(0, 11)] : 6'($urandom);
            if ($urandom_range(0, 9) == 0) op = 6'($urandom);
            run_alu("rand_alu", op, fn, $urandom, ($urandom_range(0, 3) == 0) ? al_a : $urandom);
        end

        // random top-level fetch+execute
        for (int i = 0; i < 20; i++) begin
            addr = {20'($urandom), 10'($urandom_range(0, 12)), 2'($urandom)};
            top_step("rand_top", addr, $urandom, $urandom);
        end

        // SW then LW, including address wrap and ignored low bits
        mem_write(32'h10, 32'hDEAD_BEEF);
        mem_read("lw_0x10", 32'h10);
        check("lw_0x10_lit", dmem_out, 32'hDEAD_BEEF);
        mem_read("lw_0x410_wrap", 32'h410);
        check("lw_0x410_lit", dmem_out, 32'hDEAD_BEEF);
        mem_read("lw_0x13_low", 32'h13);
        mem_read("lw_0x14_other", 32'h14);

        // random writes/reads
        for (int i = 0; i < 30; i++) begin
            mem_write($urandom, $urandom);
        end
        for (int i = 0; i < 30; i++) begin
            mem_read("rand_lw", $urandom);
        end
        mem_write(32'h20, 32'h1357_9BDF);

        // async reset between edges
        @(negedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        mem_read("async_rst_0x10", 32'h10);
        mem_read("async_rst_0x20", 32'h20);
        check("async_rst_0x20_lit", dmem_out, 32'h0);
        for (int i = 0; i < 10; i++) begin
            mem_read("async_rst_rand", $urandom);
        end

        // write attempt while reset held
        mem_write(32'h20, 32'hCAFE_F00D);
        mem_read("rst_write_blocked", 32'h20);
        @(negedge clk);
        rst = 1'b0;
        mem_read("after_rst_release", 32'h20);

        // writes work again after reset
        mem_write(32'h24, 32'h0BAD_F00D);
        mem_read("post_rst_lw", 32'h24);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        n_errors++;
        $display("FAIL timeout: observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "timeout");
    end

endmodule
